morse_key_decoder: RTL
======================

MORSE_KEY_DECODER -- requirements
Module: morse_key_decoder

Interface
REQ-001 SHALL have parameter DOT_MAX, default 4, meaning the longest press in cycles that is classified as a dot.
REQ-002 SHALL have parameter LONG_MAX, default 16, meaning the longest legal press in cycles; longer presses are errors.
REQ-003 SHALL have parameter GAP, default 8, meaning the number of consecutive released cycles that ends an incomplete entry.
REQ-004 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port enable  input  1  decoder active; low aborts any entry.
REQ-007 SHALL have port key  input  1  debounced, clk-synchronous key level; 1 = pressed.
REQ-008 SHALL have port digit  output  4  decoded digit 0-9; held until the next digit_valid.
REQ-009 SHALL have port digit_valid  output  1  one-cycle pulse when digit is updated.
REQ-010 SHALL have port error  output  1  one-cycle pulse on any rejected entry.
REQ-011 SHALL have port sym_count  output  3  number of symbols accepted in the current entry, 0-5.
REQ-012 SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-013 SHALL implement a registered FSM with states IDLE, PRESS, GAP_WAIT and REL_WAIT; key is sampled on every rising edge.
REQ-014 IDLE: on key=1 with enable=1, SHALL go to PRESS with press_cnt=1.
REQ-015 PRESS with key=1: press_cnt SHALL increment; on the edge where press_cnt would become LONG_MAX+1, the block SHALL pulse error, clear the entry, and go to REL_WAIT.
REQ-016 PRESS with key=0: a press_cnt <= DOT_MAX SHALL shift in 0 (dot); otherwise it SHALL shift in 1 (dash); the first symbol ends as the MSB of a 5-bit pattern, and sym_count SHALL increment.
REQ-017 If that release makes sym_count 5, then on the same edge the block SHALL decode, output the result, clear sym_count and pattern, and go to IDLE; otherwise it SHALL go to GAP_WAIT with gap_cnt=1.
REQ-018 Decode table (dot=0, dash=1): 01111=1, 00111=2, 00011=3, 00001=4, 00000=5, 10000=6, 11000=7, 11100=8, 11110=9, 11111=0.
REQ-019 A valid pattern SHALL load digit and pulse digit_valid for one cycle.
REQ-020 Any of the other 22 patterns SHALL pulse error for one cycle and leave digit unchanged.
REQ-021 GAP_WAIT with key=1: SHALL go to PRESS with press_cnt=1.
REQ-022 GAP_WAIT with key=0: gap_cnt SHALL increment; on the edge where gap_cnt would reach GAP, the block SHALL pulse error, clear the entry, and go to IDLE.
REQ-023 REL_WAIT: SHALL ignore key=1 and return to IDLE on the first key=0 sample, with no pulse.
REQ-024 enable=0 in any state SHALL force IDLE, clear the counters, sym_count and pattern on the next edge, and suppress digit_valid and error; digit SHALL hold.
REQ-025 digit_valid and error SHALL never be high in the same cycle.
REQ-026 All outputs SHALL be registered; latency from the first key=0 sample of the 5th press to digit_valid is 0 cycles (asserted from that same edge).
REQ-027 Boundaries SHALL be: press of DOT_MAX cycles = dot; DOT_MAX+1 = dash; LONG_MAX = dash; LONG_MAX+1 = error. A press starting after GAP-1 low cycles continues the entry.
REQ-028 press_cnt and gap_cnt SHALL be wide enough for LONG_MAX+1 and GAP without wrap.

Reset
REQ-029 rst=0 SHALL immediately force IDLE, digit=0, digit_valid=0, error=0, sym_count=0, busy=0, and clear all counters and the pattern, regardless of the clock.
REQ-030 Release of rst SHALL be followed by normal operation from the next rising edge; a key already held at release SHALL be treated as a new press.

Verification
REQ-031 Presses of 2,2,6,6,6 cycles with 2-cycle gaps -> one digit_valid pulse with digit=2, sym_count=0, busy=0 afterwards.
REQ-032 Five presses of 6 cycles each -> digit=0 pulse; a following entry of five 1-cycle presses -> digit=5 pulse.
REQ-033 Pattern dot-dash-dot-dash-dot -> one error pulse, no digit_valid, digit unchanged.
REQ-034 Three dots, then key low for 8 cycles -> error pulse on the 8th low cycle, sym_count=0.
REQ-035 Key held for 20 cycles -> error pulse on the 17th cycle; busy stays high until release, then IDLE with no further pulses.
REQ-036 rst low, then enable low, each after 3 symbols -> all outputs cleared as specified; a next full entry decodes correctly.

Source files
------------

// File: rtl/morse_key_decoder.sv
// Morse-style key decoder: classifies key presses as dots or dashes, collects
// five symbols and decodes them to a digit 0-9, flagging malformed entries.
module morse_key_decoder #(
  parameter int DOT_MAX  = 4,
  parameter int LONG_MAX = 16,
  parameter int GAP      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       key,
  output logic [3:0] digit,
  output logic       digit_valid,
  output logic       error,
  output logic [2:0] sym_count,
  output logic       busy
);

  localparam int PW = $clog2(LONG_MAX + 2);
  localparam int GW = $clog2(GAP + 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS,
    GAP_WAIT,
    REL_WAIT
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] value;
  } decode_t;

  function automatic decode_t decode(input logic [4:0] pattern);
    decode_t d;
    d.valid = 1'b1;
    d.value = 4'd0;
    case (pattern)
      5'b01111: d.value = 4'd1;
      5'b00111: d.value = 4'd2;
      5'b00011: d.value = 4'd3;
      5'b00001: d.value = 4'd4;
      5'b00000: d.value = 4'd5;
      5'b10000: d.value = 4'd6;
      5'b11000: d.value = 4'd7;
      5'b11100: d.value = 4'd8;
      5'b11110: d.value = 4'd9;
      5'b11111: d.value = 4'd0;
      default:  d.valid = 1'b0;
    endcase
    return d;
  endfunction

  state_t        state_q;
  logic [PW-1:0] press_cnt_q;
  logic [GW-1:0] gap_cnt_q;
  logic [4:0]    pattern_q;
  logic [2:0]    sym_count_q;
  logic [3:0]    digit_q;
  logic          digit_valid_q;
  logic          error_q;
  logic          busy_q;

  // The symbol being released is appended at the LSB so the first one ends up as the MSB.
  logic       sym_bit;
  logic [4:0] pattern_shift;
  decode_t    dec;

  assign sym_bit       = (press_cnt_q > PW'(DOT_MAX));
  assign pattern_shift = {pattern_q[3:0], sym_bit};
  assign dec           = decode(pattern_shift);

  // NOTE: every register here, including the pattern, is cleared by the async
  // reset, and sequential state is only ever written with non-blocking '<='.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      press_cnt_q   <= '0;
      gap_cnt_q     <= '0;
      pattern_q     <= '0;
      sym_count_q   <= '0;
      digit_q       <= '0;
      digit_valid_q <= 1'b0;
      error_q       <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      digit_valid_q <= 1'b0;
      error_q       <= 1'b0;
      if (!enable) begin
        state_q     <= IDLE;
        busy_q      <= 1'b0;
        press_cnt_q <= '0;
        gap_cnt_q   <= '0;
        pattern_q   <= '0;
        sym_count_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (key) begin
              state_q     <= PRESS;
              busy_q      <= 1'b1;
              press_cnt_q <= PW'(1);
            end
          end
          PRESS: begin
            if (key) begin
              if (press_cnt_q == PW'(LONG_MAX)) begin
                error_q     <= 1'b1;
                state_q     <= REL_WAIT;
                press_cnt_q <= '0;
                pattern_q   <= '0;
                sym_count_q <= '0;
              end else begin
                press_cnt_q <= press_cnt_q + PW'(1);
              end
            end else if (sym_count_q == 3'd4) begin
              if (dec.valid) begin
                digit_q       <= dec.value;
                digit_valid_q <= 1'b1;
              end else begin
                error_q <= 1'b1;
              end
              state_q     <= IDLE;
              busy_q      <= 1'b0;
              press_cnt_q <= '0;
              pattern_q   <= '0;
              sym_count_q <= '0;
            end else begin
              pattern_q   <= pattern_shift;
              sym_count_q <= sym_count_q + 3'd1;
              press_cnt_q <= '0;
              gap_cnt_q   <= GW'(1);
              state_q     <= GAP_WAIT;
            end
          end
          GAP_WAIT: begin
            if (key) begin
              state_q     <= PRESS;
              press_cnt_q <= PW'(1);
              gap_cnt_q   <= '0;
            end else if (gap_cnt_q == GW'(GAP - 1)) begin
              error_q     <= 1'b1;
              state_q     <= IDLE;
              busy_q      <= 1'b0;
              gap_cnt_q   <= '0;
              pattern_q   <= '0;
              sym_count_q <= '0;
            end else begin
              gap_cnt_q <= gap_cnt_q + GW'(1);
            end
          end
          REL_WAIT: begin
            if (!key) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign digit       = digit_q;
  assign digit_valid = digit_valid_q;
  assign error       = error_q;
  assign sym_count   = sym_count_q;
  assign busy        = busy_q;

endmodule
